// File: rtl/siso_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | siso_pkg: shared state encoding and default sizing for siso_frame_ctrl|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package siso_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/siso_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | siso_shift_core: WIDTH-bit MSB-first shift register with load         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module siso_shift_core
  import siso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_en_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [WIDTH-1:0] shifted_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  // shifted_o is the word the register will hold after the current shift edge
  assign shifted_o = {sreg_q[WIDTH-2:0], serial_i};
  assign serial_o  = sreg_q[WIDTH-1];

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_en_i) begin
      sreg_d = shifted_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/siso_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | siso_frame_ctrl: frame sequencer for a SISO serial shift link         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module siso_frame_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             shift_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             accept;
  logic             last_bit;
  logic             gap_done;
  logic             core_msb;
  logic [WIDTH-1:0] shifted;

  // in_ready is gated by rst so the producer sees "not ready" during reset
  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign shift_en   = (state_q == S_SHIFT);
  assign busy       = (state_q != S_IDLE);
  assign serial_out = shift_en && core_msb;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign last_bit   = (bitcnt_q == CNT_W'(WIDTH - 1));

  siso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .data_i     (in_data),
    .shift_en_i (shift_en),
    .serial_i   (serial_in),
    .serial_o   (core_msb),
    .shifted_o  (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            bitcnt_q <= '0;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            out_data_q  <= shifted;
            out_valid_q <= 1'b1;
            bitcnt_q    <= '0;
            state_q     <= (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            bitcnt_q <= bitcnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
      logic [GW-1:0] gapcnt_q;

      assign gap_done = (gapcnt_q == GW'(GAP - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          gapcnt_q <= '0;
        end else if (state_q == S_GAP) begin
          gapcnt_q <= gap_done ? '0 : gapcnt_q + GW'(1);
        end
      end
    end else begin : g_no_gap
      assign gap_done = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_siso_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_siso_frame_ctrl: directed bench for GAP=2 and GAP=0 builds         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_siso_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, serial_in, serial_out, shift_en, out_valid, busy;
  logic [7:0] in_data, out_data;
  logic       loop_en, sin_drv;

  logic       v0, rdy0, sin0, sout0, sen0, ov0, busy0;
  logic [7:0] d0, od0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] pat;

  assign serial_in = loop_en ? serial_out : sin_drv;
  assign sin0      = sout0;

  siso_frame_ctrl #(.WIDTH(8), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .serial_in(serial_in), .serial_out(serial_out), .shift_en(shift_en),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  siso_frame_ctrl #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .serial_in(sin0), .serial_out(sout0), .shift_en(sen0),
    .out_valid(ov0), .out_data(od0), .busy(busy0)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; loop_en = 1'b0; sin_drv = 1'b0;
    v0 = 1'b0; d0 = 8'h00;

    // reset state
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_serial_out", {31'd0, serial_out}, 32'd0);
    #12;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_serial_out", {31'd0, serial_out}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_out_data", {24'd0, out_data}, 32'h00);
    tick;

    // frame 1: 0xA5 in loopback
    loop_en = 1'b1; in_data = 8'hA5; in_valid = 1'b1; pat = 8'hA5;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("f1_bit", {31'd0, serial_out}, {31'd0, pat[7-k]});
      chk("f1_shift_en", {31'd0, shift_en}, 32'd1);
      chk("f1_busy", {31'd0, busy}, 32'd1);
      chk("f1_in_ready", {31'd0, in_ready}, 32'd0);
      chk("f1_no_valid", {31'd0, out_valid}, 32'd0);
      tick;
    end
    chk("f1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("f1_out_data", {24'd0, out_data}, 32'hA5);
    chk("f1_gap_busy", {31'd0, busy}, 32'd1);
    chk("f1_gap_shift_en", {31'd0, shift_en}, 32'd0);
    chk("f1_gap_serial_out", {31'd0, serial_out}, 32'd0);
    tick;
    chk("f1_pulse_1cyc", {31'd0, out_valid}, 32'd0);
    chk("f1_gap2_busy", {31'd0, busy}, 32'd1);
    chk("f1_gap2_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("f1_idle_busy", {31'd0, busy}, 32'd0);
    chk("f1_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("f1_hold_data", {24'd0, out_data}, 32'hA5);

    // frame 2: transmit zeros, capture 0xCD from serial_in
    loop_en = 1'b0; in_data = 8'h00; in_valid = 1'b1; pat = 8'hCD;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sin_drv = pat[7-k];
      chk("f2_tx_zero", {31'd0, serial_out}, 32'd0);
      tick;
    end
    chk("f2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("f2_out_data", {24'd0, out_data}, 32'hCD);
    tick;
    tick;

    // frame 3: back-to-back 0xFF then 0x0F with in_valid held
    loop_en = 1'b1; in_data = 8'hFF; in_valid = 1'b1;
    tick;
    in_data = 8'h0F;
    for (int c = 1; c <= 10; c++) begin
      chk("f3_ready_low", {31'd0, in_ready}, 32'd0);
      if (c <= 8) chk("f3_first_bits", {31'd0, serial_out}, 32'd1);
      tick;
    end
    chk("f3_ready_t11", {31'd0, in_ready}, 32'd1);
    pat = 8'h0F;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("f3_second_bits", {31'd0, serial_out}, {31'd0, pat[7-k]});
      tick;
    end
    chk("f3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("f3_out_data", {24'd0, out_data}, 32'h0F);
    tick;
    tick;

    // frame 4: reset after 4 bits of 0xF0, then a clean 0x3C frame
    in_data = 8'hF0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    #1;
    rst = 1'b1;
    #1;
    chk("abort_serial_out", {31'd0, serial_out}, 32'd0);
    chk("abort_shift_en", {31'd0, shift_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_data", {24'd0, out_data}, 32'h00);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick;
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_idle", {31'd0, busy}, 32'd0);
    end
    in_data = 8'h3C; in_valid = 1'b1; pat = 8'h3C;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("f4_bits", {31'd0, serial_out}, {31'd0, pat[7-k]});
      tick;
    end
    chk("f4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("f4_out_data", {24'd0, out_data}, 32'h3C);
    tick;
    tick;

    // GAP=0 build: 0x81 then 0x7E, accept coincides with first out_valid
    d0 = 8'h81; v0 = 1'b1; pat = 8'h81;
    tick;
    d0 = 8'h7E;
    for (int k = 0; k < 8; k++) begin
      chk("g0_shift_en_a", {31'd0, sen0}, 32'd1);
      chk("g0_bits_a", {31'd0, sout0}, {31'd0, pat[7-k]});
      chk("g0_ready_low_a", {31'd0, rdy0}, 32'd0);
      tick;
    end
    chk("g0_out_valid_a", {31'd0, ov0}, 32'd1);
    chk("g0_out_data_a", {24'd0, od0}, 32'h81);
    chk("g0_ready_with_valid", {31'd0, rdy0}, 32'd1);
    chk("g0_idle_shift_en", {31'd0, sen0}, 32'd0);
    pat = 8'h7E;
    tick;
    v0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("g0_shift_en_b", {31'd0, sen0}, 32'd1);
      chk("g0_bits_b", {31'd0, sout0}, {31'd0, pat[7-k]});
      chk("g0_no_valid_b", {31'd0, ov0}, 32'd0);
      tick;
    end
    chk("g0_out_valid_b", {31'd0, ov0}, 32'd1);
    chk("g0_out_data_b", {24'd0, od0}, 32'h7E);
    chk("g0_no_gap_ready", {31'd0, rdy0}, 32'd1);
    tick;
    chk("g0_pulse_1cyc", {31'd0, ov0}, 32'd0);
    chk("g0_idle_busy", {31'd0, busy0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
